pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_if.sv | 28 ++
 rtl/pipelined_cla_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_cla_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined lookahead adder.
// The adder sits on the slave side; whoever feeds operands and takes results is the master.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Add/subtract unit split into STAGES carry-lookahead slices, one slice per pipeline stage.
// Operands skew in and result slices deskew out through full-width stage registers.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int W = (STAGES >= 1) ? WIDTH / STAGES : 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    // Flattened lookahead: every carry is a sum of products of slice G/P and the slice carry-in.
    // Returns {carry out, carry into slice MSB, sum}.
    function automatic logic [W+1:0] cla(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
        logic [W-1:0] p;
        logic [W-1:0] g;
        logic [W:0]   c;
        logic         t;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) t = t & p[j];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[W], c[W-1], p ^ c[W-1:0]};
    endfunction

    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] bx_q [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];
    logic             ovf_q;
    logic             zero_q;

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_bx[STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] d_s   [STAGES];
    logic             d_c   [STAGES];
    logic             c_msb;
    logic             d_ovf;
    logic             d_zero;
    logic             advance;

    assign advance      = !(v_q[STAGES-1] && !bus.out_ready);
    assign bus.in_ready = advance;

    always_comb begin
        src_a[0]  = bus.a;
        src_bx[0] = bus.sub ? ~bus.b : bus.b;
        src_s[0]  = '0;
        src_c[0]  = bus.sub | bus.cin;
        src_v[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]  = a_q[k-1];
            src_bx[k] = bx_q[k-1];
            src_s[k]  = s_q[k-1];
            src_c[k]  = c_q[k-1];
            src_v[k]  = v_q[k-1];
        end
    end

    always_comb begin
        logic [W+1:0] r;
        r     = '0;
        c_msb = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            r                = cla(src_a[k][k*W +: W], src_bx[k][k*W +: W], src_c[k]);
            d_s[k]           = src_s[k];
            d_s[k][k*W +: W] = r[W-1:0];
            d_c[k]           = r[W+1];
            if (k == STAGES - 1) c_msb = r[W];
        end
        d_ovf  = c_msb ^ d_c[STAGES-1];
        d_zero = (d_s[STAGES-1] == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= src_a[k];
                bx_q[k] <= src_bx[k];
                s_q[k]  <= d_s[k];
                c_q[k]  <= d_c[k];
                v_q[k]  <= src_v[k];
            end
            ovf_q  <= d_ovf;
            zero_q <= d_zero;
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.result    = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder (WIDTH=32, STAGES=4) using a result
// queue filled at operand acceptance and drained by an output monitor.
module tb_pipelined_cla_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
        logic             z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hs_count = 0;
    exp_t exp_q[$];
    int   hs_cyc[$];

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 33-bit sum for carry, sign rule for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic ci, input logic s);
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   full;
        exp_t             e;
        bx   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
        e.res = full[WIDTH-1:0];
        e.co  = full[WIDTH];
        e.ov  = (a[WIDTH-1] == bx[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
        e.z   = (e.res == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_t e;
            hs_count++;
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result",   bus.result,   e.res);
                chk("cout",     bus.cout,     e.co);
                chk("overflow", bus.overflow, e.ov);
                chk("zero",     bus.zero,     e.z);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                        input logic c_i, input logic s_i);
        int n = 0;
        bus.a = a_i; bus.b = b_i; bus.cin = c_i; bus.sub = s_i; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        exp_q.push_back(model(a_i, b_i, c_i, s_i));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, STAGES - 1);
    endtask

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] r, input logic co,
                           input logic ov, input logic z);
        chk({tag, "_res"}, bus.result,   r);
        chk({tag, "_co"},  bus.cout,     co);
        chk({tag, "_ov"},  bus.overflow, ov);
        chk({tag, "_z"},   bus.zero,     z);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int t0;
        int hs0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Carry ripples through all four slices; first transfer on first edge after reset.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check_latency("lat_wrap");
        chk_out("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain("drain_wrap");

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check_latency("lat_ovf");
        chk_out("ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drain("drain_ovf");

        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        check_latency("lat_sub");
        chk_out("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drain("drain_sub");

        send(32'h0000_1234, 32'h0000_0001, 1'b1, 1'b0);
        check_latency("lat_cin");
        chk_out("cin", 32'h0000_1236, 1'b0, 1'b0, 1'b0);
        drain("drain_cin");

        // Back-to-back burst of random operations.
        hs_cyc.delete();
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 0) t0 = cyc;
        end
        drain("drain_burst");
        chk("burst_count", hs_cyc.size(), 8);
        if (hs_cyc.size() == 8) begin
            chk("burst_first_cyc", hs_cyc[0], t0 + STAGES - 1);
            chk("burst_last_cyc",  hs_cyc[7], t0 + STAGES + 6);
        end

        // Backpressure with a full pipeline.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        hs0 = hs_count;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid",    bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready,  0);
            chk("stall_result",   bus.result,    exp_q[0].res);
            chk("stall_cout",     bus.cout,      exp_q[0].co);
            chk("stall_overflow", bus.overflow,  exp_q[0].ov);
            chk("stall_zero",     bus.zero,      exp_q[0].z);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_stall");
        chk("stall_delivered", hs_count - hs0, 4);
        tick();
        chk("stall_empty", bus.out_valid, 0);

        // Reset with two operations in flight.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h0000_0001, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_valid",  bus.out_valid, 0);
        chk("midrst_result", bus.result,    0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        hs0 = hs_count;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_idle", bus.out_valid, 0);
            tick();
        end
        chk("post_rst_no_stale", hs_count - hs0, 0);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
        check_latency("lat_post_rst");
        chk_out("post_rst", 32'h0000_0007, 1'b0, 1'b0, 1'b0);
        drain("drain_post_rst");

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
